// File: rtl/rgb_hue_fader_pkg.sv
// ---------------------------------------------------------------------------
// rgb_fader_pkg
// Shared types and helpers for the RGB hue fader.
//   mode_e          : run mode of the fader (CYCLE, HOLD, STEP, OFF)
//   SEG_RY..SEG_MR  : hue wheel segment numbers, red->yellow .. magenta->red
//   calc_step_div() : clock cycles per ramp step for a given clock, revolution
//                     time and PWM resolution (never below 1)
// ---------------------------------------------------------------------------
package rgb_fader_pkg;

    typedef enum logic [1:0] {
        CYCLE = 2'd0,
        HOLD  = 2'd1,
        STEP  = 2'd2,
        OFF   = 2'd3
    } mode_e;

    localparam logic [2:0] SEG_RY = 3'd0;
    localparam logic [2:0] SEG_YG = 3'd1;
    localparam logic [2:0] SEG_GC = 3'd2;
    localparam logic [2:0] SEG_CB = 3'd3;
    localparam logic [2:0] SEG_BM = 3'd4;
    localparam logic [2:0] SEG_MR = 3'd5;

    // One revolution is 6 segments of 2^bits ramp steps each; the product is
    // kept in 64 bits because clkHz*cycleMs overflows 32 bits at 12 MHz.
    function automatic int calc_step_div(input longint clkHz,
                                         input longint cycleMs,
                                         input int     bits);
        longint div;
        div = clkHz * cycleMs / 1000 / (6 * (longint'(1) << bits));
        return (div < 1) ? 1 : int'(div);
    endfunction

endpackage

// File: rtl/rgb_hue_fader_pwm_channel.sv
// ---------------------------------------------------------------------------
// pwm_channel
// One PWM output: latches a new duty only at the period boundary, compares it
// against the shared counter and drives a registered, polarity-adjusted pin.
// Optional macro GAMMA_EN adds one extra register stage on the lit signal.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   pwmCnt_i       : shared free-running PWM counter
//   latch_i        : high for the last count of a period (counter == MAX)
//   duty_i         : duty to take for the next period
//   pin_o          : LED drive, inverted when ACTIVE_LOW
// ---------------------------------------------------------------------------
module pwm_channel #(
    parameter int N          = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [N-1:0] pwmCnt_i,
    input  logic         latch_i,
    input  logic [N-1:0] duty_i,
    output logic         pin_o
);

    logic [N-1:0] duty_q, duty_d;
    logic         pin_q, pin_d;
    logic         lit;
`ifdef GAMMA_EN
    logic         litDly_q, litDly_d;
`endif

    // Duty is only ever replaced on the period boundary, so a period that has
    // started always finishes with the duty it began with.
    always_comb begin
        lit    = (pwmCnt_i < duty_q);
        duty_d = latch_i ? duty_i : duty_q;
`ifdef GAMMA_EN
        litDly_d = lit;
        pin_d    = litDly_q ^ ACTIVE_LOW;
`else
        pin_d    = lit ^ ACTIVE_LOW;
`endif
    end

    // Reset forces the pin straight to its dark level so no partial pulse
    // escapes after reset is asserted.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            duty_q   <= '0;
            pin_q    <= ACTIVE_LOW;
`ifdef GAMMA_EN
            litDly_q <= 1'b0;
`endif
        end else begin
            duty_q   <= duty_d;
            pin_q    <= pin_d;
`ifdef GAMMA_EN
            litDly_q <= litDly_d;
`endif
        end
    end

    assign pin_o = pin_q;

endmodule

// File: rtl/rgb_hue_fader.sv
// ---------------------------------------------------------------------------
// rgb_hue_fader
// Sweeps the hue wheel R->Y->G->C->B->M->R on three PWM pins with global
// brightness scaling. Optional macro GAMMA_EN inserts a square-law stage
// before brightness scaling (and one extra cycle of pin latency).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   mode                : 0=CYCLE, 1=HOLD, 2=STEP, 3=OFF
//   brightness          : global intensity, all ones = full
//   RGB_R, RGB_G, RGB_B : PWM pins (low = lit when ACTIVE_LOW)
//   segment             : current hue segment 0..5
//   wrap                : one-cycle pulse when segment goes 5 -> 0
// ---------------------------------------------------------------------------
module rgb_hue_fader
    import rgb_fader_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int PWM_BITS   = 8,
    parameter int CYCLE_MS   = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B,
    output logic [2:0]          segment,
    output logic                wrap
);

    localparam int            N         = PWM_BITS;
    localparam logic [N-1:0]  MAX       = '1;
    localparam int            STEP_DIV  = calc_step_div(CLK_HZ, CYCLE_MS, N);
    localparam int            TICK_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);

    mode_e              modeSel;
    logic [TICK_W-1:0]  tickCnt_q, tickCnt_d;
    logic [N-1:0]       level_q, level_d;
    logic [N-1:0]       stepCnt_q, stepCnt_d;
    logic [2:0]         seg_q, seg_d;
    logic               wrap_q, wrap_d;
    logic [N-1:0]       pwmCnt_q, pwmCnt_d;
    logic               stepTick;
    logic               segAdvance;
    logic [N-1:0]       rawR, rawG, rawB;
    logic [N-1:0]       dutyR, dutyG, dutyB;
    logic [N:0]         gain;
    logic               periodEnd;

    assign modeSel = mode_e'(mode);

    // brightness+1 so that full brightness is an exact multiply by 2^N
    function automatic logic [N-1:0] scale(input logic [N-1:0] raw,
                                           input logic [N:0]   g);
        logic [2*N:0] prod;
        prod = {{(N+1){1'b0}}, raw} * {{N{1'b0}}, g};
        return prod[2*N-1:N];
    endfunction

`ifdef GAMMA_EN
    function automatic logic [N-1:0] square(input logic [N-1:0] raw);
        logic [2*N-1:0] prod;
        prod = {{N{1'b0}}, raw} * {{N{1'b0}}, raw};
        return prod[2*N-1:N];
    endfunction
`endif

    // Ramp next state. The tick divider runs in every mode; the mode seen on
    // the tick edge decides what that tick does. STEP keeps its own count of
    // ticks so the segment still advances once per 2^N ticks while the level
    // stays at 0, giving hard primary/secondary jumps at the normal rate.
    always_comb begin
        stepTick   = (tickCnt_q == TICK_LAST);
        tickCnt_d  = stepTick ? '0 : tickCnt_q + 1'b1;
        level_d    = level_q;
        stepCnt_d  = stepCnt_q;
        seg_d      = seg_q;
        wrap_d     = 1'b0;
        segAdvance = 1'b0;
        pwmCnt_d   = pwmCnt_q + 1'b1;
        case (modeSel)
            CYCLE: begin
                stepCnt_d = '0;
                if (stepTick) begin
                    if (level_q == MAX) begin
                        level_d    = '0;
                        segAdvance = 1'b1;
                    end else begin
                        level_d = level_q + 1'b1;
                    end
                end
            end
            STEP: begin
                level_d = '0;
                if (stepTick) begin
                    stepCnt_d = stepCnt_q + 1'b1;
                    if (stepCnt_q == MAX) segAdvance = 1'b1;
                end
            end
            default: begin
                stepCnt_d = '0;
            end
        endcase
        if (segAdvance) begin
            if (seg_q == SEG_MR) begin
                seg_d  = SEG_RY;
                wrap_d = 1'b1;
            end else begin
                seg_d = seg_q + 3'd1;
            end
        end
    end

    // Ramp, divider and PWM counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tickCnt_q <= '0;
            level_q   <= '0;
            stepCnt_q <= '0;
            seg_q     <= SEG_RY;
            wrap_q    <= 1'b0;
            pwmCnt_q  <= '0;
        end else begin
            tickCnt_q <= tickCnt_d;
            level_q   <= level_d;
            stepCnt_q <= stepCnt_d;
            seg_q     <= seg_d;
            wrap_q    <= wrap_d;
            pwmCnt_q  <= pwmCnt_d;
        end
    end

    // Raw hue colour: one channel at full, one ramping, one dark per segment
    always_comb begin
        rawR = '0;
        rawG = '0;
        rawB = '0;
        case (seg_q)
            SEG_RY: begin rawR = MAX;           rawG = level_q;       end
            SEG_YG: begin rawR = MAX - level_q; rawG = MAX;           end
            SEG_GC: begin rawG = MAX;           rawB = level_q;       end
            SEG_CB: begin rawG = MAX - level_q; rawB = MAX;           end
            SEG_BM: begin rawR = level_q;       rawB = MAX;           end
            SEG_MR: begin rawR = MAX;           rawB = MAX - level_q; end
            default: ;
        endcase
    end

    assign gain = {1'b0, brightness} + 1'b1;

    // Final duties offered to the channels; they are computed from the
    // current (pre-update) ramp state, so a level wrap on the latch edge
    // latches the old colour.
    always_comb begin
        dutyR = '0;
        dutyG = '0;
        dutyB = '0;
        if (modeSel != OFF) begin
`ifdef GAMMA_EN
            dutyR = scale(square(rawR), gain);
            dutyG = scale(square(rawG), gain);
            dutyB = scale(square(rawB), gain);
`else
            dutyR = scale(rawR, gain);
            dutyG = scale(rawG, gain);
            dutyB = scale(rawB, gain);
`endif
        end
    end

    assign periodEnd = (pwmCnt_q == MAX);

    pwm_channel #(.N(N), .ACTIVE_LOW(ACTIVE_LOW)) uRed (
        .clk_i(clk), .reset_i(reset), .pwmCnt_i(pwmCnt_q),
        .latch_i(periodEnd), .duty_i(dutyR), .pin_o(RGB_R)
    );

    pwm_channel #(.N(N), .ACTIVE_LOW(ACTIVE_LOW)) uGreen (
        .clk_i(clk), .reset_i(reset), .pwmCnt_i(pwmCnt_q),
        .latch_i(periodEnd), .duty_i(dutyG), .pin_o(RGB_G)
    );

    pwm_channel #(.N(N), .ACTIVE_LOW(ACTIVE_LOW)) uBlue (
        .clk_i(clk), .reset_i(reset), .pwmCnt_i(pwmCnt_q),
        .latch_i(periodEnd), .duty_i(dutyB), .pin_o(RGB_B)
    );

    assign segment = seg_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_rgb_hue_fader.sv
// ---------------------------------------------------------------------------
// tb_rgb_hue_fader
// Bench for rgb_hue_fader built with PWM_BITS=4 and a clock/period choice that
// gives two clocks per ramp step, so one hue revolution is 192 clocks.
// Honours GAMMA_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_rgb_hue_fader;

    localparam int N        = 4;
    localparam int MAXV     = 15;
    localparam int PERIOD   = 16;
    localparam int CLK_HZ   = 192;
    localparam int CYCLE_MS = 1000;
    localparam int SD       = 2;
    localparam int AL       = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   mode;
    logic [N-1:0] brightness;
    logic         RGB_R, RGB_G, RGB_B;
    logic [2:0]   segment;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    // Reference model state: hue position, dividers, latched duties, pins
    int mTick, mLevel, mSeg, mStepCnt, mWrap, mPwm;
    int mDuty[3];
    int mPin[3];
    int mLitDly[3];

    rgb_hue_fader #(
        .CLK_HZ(CLK_HZ), .PWM_BITS(N), .CYCLE_MS(CYCLE_MS), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .brightness(brightness),
        .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B),
        .segment(segment), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Colour of the hue wheel at (segment, level), then gamma and brightness
    function automatic int expectDuty(int ch, int seg, int lvl, int md, int br);
        int up, dn, raw;
        int table3[3];
        up = lvl;
        dn = MAXV - lvl;
        case (seg)
            0: table3 = '{MAXV, up, 0};
            1: table3 = '{dn, MAXV, 0};
            2: table3 = '{0, MAXV, up};
            3: table3 = '{0, dn, MAXV};
            4: table3 = '{up, 0, MAXV};
            default: table3 = '{MAXV, 0, dn};
        endcase
        if (md == 3) return 0;
        raw = table3[ch];
`ifdef GAMMA_EN
        raw = (raw * raw) / PERIOD;
`endif
        return (raw * (br + 1)) / PERIOD;
    endfunction

    // Advance the model by one rising edge using the inputs present at it
    task automatic modelEdge();
        bit tick;
        int pos;
        int nd[3];
        if (reset) begin
            mTick = 0; mLevel = 0; mSeg = 0; mStepCnt = 0; mWrap = 0; mPwm = 0;
            for (int c = 0; c < 3; c++) begin
                mDuty[c] = 0; mPin[c] = AL; mLitDly[c] = 0;
            end
            return;
        end
        tick = (mTick == SD - 1);
        for (int c = 0; c < 3; c++) begin
`ifdef GAMMA_EN
            mPin[c]    = AL ^ mLitDly[c];
            mLitDly[c] = (mPwm < mDuty[c]) ? 1 : 0;
`else
            mPin[c] = AL ^ ((mPwm < mDuty[c]) ? 1 : 0);
`endif
            nd[c] = (mPwm == MAXV) ? expectDuty(c, mSeg, mLevel, int'(mode), int'(brightness))
                                   : mDuty[c];
        end
        for (int c = 0; c < 3; c++) mDuty[c] = nd[c];
        mWrap = 0;
        case (int'(mode))
            0: begin
                mStepCnt = 0;
                if (tick) begin
                    pos = mSeg * PERIOD + mLevel + 1;
                    if (pos == 6 * PERIOD) begin
                        pos = 0;
                        mWrap = 1;
                    end
                    mSeg   = pos / PERIOD;
                    mLevel = pos % PERIOD;
                end
            end
            2: begin
                mLevel = 0;
                if (tick) begin
                    mStepCnt++;
                    if (mStepCnt == PERIOD) begin
                        mStepCnt = 0;
                        mSeg = (mSeg + 1) % 6;
                        if (mSeg == 0) mWrap = 1;
                    end
                end
            end
            default: mStepCnt = 0;
        endcase
        mTick = tick ? 0 : mTick + 1;
        mPwm  = (mPwm + 1) % PERIOD;
    endtask

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        checkOne("RGB_R", 32'(RGB_R), 32'(mPin[0]));
        checkOne("RGB_G", 32'(RGB_G), 32'(mPin[1]));
        checkOne("RGB_B", 32'(RGB_B), 32'(mPin[2]));
        checkOne("segment", 32'(segment), 32'(mSeg));
        checkOne("wrap", 32'(wrap), 32'(mWrap));
    endtask

    // Drive inputs after the falling edge, step one clock, check at the next falling edge
    task automatic applyStimulus(input logic r, input logic [1:0] m, input logic [N-1:0] b);
        reset      = r;
        mode       = m;
        brightness = b;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    // Count lit cycles per channel over one PWM period
    task automatic countLit(input logic [1:0] m, input logic [N-1:0] b,
                            output int litR, output int litG, output int litB);
        litR = 0; litG = 0; litB = 0;
        for (int i = 0; i < PERIOD; i++) begin
            applyStimulus(1'b0, m, b);
            if (RGB_R == 1'b0) litR++;
            if (RGB_G == 1'b0) litG++;
            if (RGB_B == 1'b0) litB++;
        end
    endtask

    initial begin
        int wrapCount, wrapAt, litR, litG, litB, holdSeg;
        int expR15, expG15, expR7;
        logic [1:0] curMode;
        logic [N-1:0] curBright;
`ifdef GAMMA_EN
        expR15 = 14; expG15 = 4; expR7 = 7;
`else
        expR15 = 15; expG15 = 8; expR7 = 7;
`endif
        $display("[TB] reset phase");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'd0, 4'd15);

        // One full revolution from reset: wrap exactly once, on clock 192
        $display("[TB] full revolution in CYCLE mode");
        wrapCount = 0;
        wrapAt    = -1;
        for (int i = 1; i <= 200; i++) begin
            applyStimulus(1'b0, 2'd0, 4'd15);
            if (wrap === 1'b1) begin
                wrapCount++;
                wrapAt = i;
            end
        end
        checkOne("wrapCount", 32'(wrapCount), 32'd1);
        checkOne("wrapAt", 32'(wrapAt), 32'd192);

        // Park at segment 0, level 8 and measure one period of each pin
        $display("[TB] seg0 level8 hold");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'd0, 4'd15);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 2'd0, 4'd15);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 2'd1, 4'd15);
        countLit(2'd1, 4'd15, litR, litG, litB);
        checkOne("litR_b15", 32'(litR), 32'(expR15));
        checkOne("litG_b15", 32'(litG), 32'(expG15));
        checkOne("litB_b15", 32'(litB), 32'd0);
        holdSeg = int'(segment);
        for (int i = 0; i < 500; i++) applyStimulus(1'b0, 2'd1, 4'd7);
        checkOne("holdSeg", 32'(segment), 32'(holdSeg));
        countLit(2'd1, 4'd7, litR, litG, litB);
        checkOne("litR_b7", 32'(litR), 32'(expR7));

        // OFF: everything dark once the next period starts
        $display("[TB] OFF mode");
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 2'd3, 4'd15);
        countLit(2'd3, 4'd15, litR, litG, litB);
        checkOne("offLit", 32'(litR + litG + litB), 32'd0);

        // Randomised modes, brightness and occasional reset pulses
        $display("[TB] random phase");
        curMode   = 2'd0;
        curBright = 4'd15;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) curMode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) curBright = 4'($urandom_range(0, 15));
            applyStimulus(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, curMode, curBright);
        end

        // STEP mode long enough to jump through every segment
        $display("[TB] STEP mode");
        for (int i = 0; i < 400; i++) applyStimulus(1'b0, 2'd2, 4'($urandom_range(0, 15)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
